// File: rtl/gprs_bank_if.sv
// Decode/writeback-side bundle for the gprs_bank register file: read ports,
// scoreboard allocate, write port and bulk-clear handshake.
interface gprs_bank_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              rd1_busy;
    logic              rd2_busy;
    logic [ADDR_W-1:0] ws;
    logic [DATA_W-1:0] wd;
    logic              we;
    logic              alloc_en;
    logic [ADDR_W-1:0] alloc_reg;
    logic              clr_req;
    logic              clr_busy;
    logic              clr_done;

    modport master (
        output rs1, rs2, ws, wd, we, alloc_en, alloc_reg, clr_req,
        input  rd1, rd2, rd1_busy, rd2_busy, clr_busy, clr_done
    );

    modport slave (
        input  rs1, rs2, ws, wd, we, alloc_en, alloc_reg, clr_req,
        output rd1, rd2, rd1_busy, rd2_busy, clr_busy, clr_done
    );
endinterface

// File: rtl/gprs_bank.sv
// Parametrised general-purpose register file with pending-write scoreboard,
// optional hardwired R0, optional write-to-read bypass and a bulk-clear engine.
module gprs_bank #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter int ZERO_R0 = 0,
    parameter int BYPASS  = 1
) (
    input logic        clk,
    input logic        reset,
    gprs_bank_if.slave bus
);
    localparam int              NUM_REGS = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_idx;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0] pending;

    logic idle;
    logic wr_ok;
    logic alloc_ok;
    logic clr_start;
    logic byp1;
    logic byp2;

    assign idle      = (state == S_IDLE);
    // Writes and allocates to R0 are dropped entirely when it is hardwired.
    assign wr_ok     = idle && bus.we && !((ZERO_R0 != 0) && (bus.ws == '0));
    assign alloc_ok  = idle && bus.alloc_en && !((ZERO_R0 != 0) && (bus.alloc_reg == '0));
    assign clr_start = idle && bus.clr_req;
    assign byp1      = (BYPASS != 0) && wr_ok && (bus.ws == bus.rs1);
    assign byp2      = (BYPASS != 0) && wr_ok && (bus.ws == bus.rs2);

    // ------------------------------------------------------------------
    // Clear FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // flop samples pre-edge values regardless of block ordering.
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise a missed branch infers a latch.
        state_nxt    = state;
        bus.clr_busy = 1'b0;
        bus.clr_done = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.clr_req) state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                bus.clr_busy = 1'b1;
                if (clr_idx == LAST_IDX) state_nxt = S_DONE;
            end
            S_DONE: begin
                bus.clr_busy = 1'b1;
                bus.clr_done = 1'b1;
                state_nxt    = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_idx <= '0;
        end else if (clr_start) begin
            clr_idx <= '0;
        end else if (state == S_CLEAR) begin
            clr_idx <= clr_idx + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Register storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: this array is reset on purpose (architectural zero state),
            // which keeps it in flops rather than a RAM macro.
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (state == S_CLEAR) begin
            regs[clr_idx] <= '0;
        end else if (wr_ok) begin
            regs[bus.ws] <= bus.wd;
        end
    end

    // Scoreboard: a later non-blocking assignment to the same bit wins, so
    // alloc beats a same-cycle write, and a clear start beats both.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else if (clr_start) begin
            pending <= '0;
        end else begin
            if (wr_ok)    pending[bus.ws]        <= 1'b0;
            if (alloc_ok) pending[bus.alloc_reg] <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    always_comb begin
        bus.rd1      = regs[bus.rs1];
        bus.rd1_busy = pending[bus.rs1];
        if (byp1) begin
            bus.rd1      = bus.wd;
            bus.rd1_busy = 1'b0;
        end
        if ((ZERO_R0 != 0) && (bus.rs1 == '0)) begin
            bus.rd1      = '0;
            bus.rd1_busy = 1'b0;
        end
    end

    always_comb begin
        bus.rd2      = regs[bus.rs2];
        bus.rd2_busy = pending[bus.rs2];
        if (byp2) begin
            bus.rd2      = bus.wd;
            bus.rd2_busy = 1'b0;
        end
        if ((ZERO_R0 != 0) && (bus.rs2 == '0)) begin
            bus.rd2      = '0;
            bus.rd2_busy = 1'b0;
        end
    end
endmodule

// File: tb/tb_gprs_bank.sv
// Randomised + directed bench for gprs_bank; three parameter sets share one
// stimulus stream and are checked against a per-configuration array model.
module tb_gprs_bank;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  rs1, rs2, ws, alloc_reg;
    logic [15:0] wd;
    logic        we, alloc_en, clr_req;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // c0: ZERO_R0=0 BYPASS=1, c1: ZERO_R0=1 BYPASS=0, c2: ZERO_R0=1 BYPASS=1
    gprs_bank_if #(.DATA_W(16), .ADDR_W(3)) bus0 ();
    gprs_bank_if #(.DATA_W(16), .ADDR_W(3)) bus1 ();
    gprs_bank_if #(.DATA_W(16), .ADDR_W(3)) bus2 ();

    gprs_bank #(.DATA_W(16), .ADDR_W(3), .ZERO_R0(0), .BYPASS(1)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    gprs_bank #(.DATA_W(16), .ADDR_W(3), .ZERO_R0(1), .BYPASS(0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    gprs_bank #(.DATA_W(16), .ADDR_W(3), .ZERO_R0(1), .BYPASS(1)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    assign bus0.rs1 = rs1; assign bus0.rs2 = rs2; assign bus0.ws = ws; assign bus0.wd = wd;
    assign bus0.we = we; assign bus0.alloc_en = alloc_en; assign bus0.alloc_reg = alloc_reg;
    assign bus0.clr_req = clr_req;
    assign bus1.rs1 = rs1; assign bus1.rs2 = rs2; assign bus1.ws = ws; assign bus1.wd = wd;
    assign bus1.we = we; assign bus1.alloc_en = alloc_en; assign bus1.alloc_reg = alloc_reg;
    assign bus1.clr_req = clr_req;
    assign bus2.rs1 = rs1; assign bus2.rs2 = rs2; assign bus2.ws = ws; assign bus2.wd = wd;
    assign bus2.we = we; assign bus2.alloc_en = alloc_en; assign bus2.alloc_reg = alloc_reg;
    assign bus2.clr_req = clr_req;

    logic [15:0] o_rd1 [3];
    logic [15:0] o_rd2 [3];
    logic        o_b1 [3], o_b2 [3], o_cb [3], o_cd [3];

    assign o_rd1[0] = bus0.rd1; assign o_rd2[0] = bus0.rd2; assign o_b1[0] = bus0.rd1_busy;
    assign o_b2[0] = bus0.rd2_busy; assign o_cb[0] = bus0.clr_busy; assign o_cd[0] = bus0.clr_done;
    assign o_rd1[1] = bus1.rd1; assign o_rd2[1] = bus1.rd2; assign o_b1[1] = bus1.rd1_busy;
    assign o_b2[1] = bus1.rd2_busy; assign o_cb[1] = bus1.clr_busy; assign o_cd[1] = bus1.clr_done;
    assign o_rd1[2] = bus2.rd1; assign o_rd2[2] = bus2.rd2; assign o_b1[2] = bus2.rd1_busy;
    assign o_b2[2] = bus2.rd2_busy; assign o_cb[2] = bus2.clr_busy; assign o_cd[2] = bus2.clr_done;

    // ---------------- reference model ----------------
    logic [15:0] m_reg  [3][8];
    bit          m_pend [3][8];
    int          phase;  // 0 idle, 1..8 clearing entry phase-1, 9 done pulse

    function automatic bit cfg_z(int c); return c != 0; endfunction
    function automatic bit cfg_b(int c); return c != 1; endfunction

    function automatic bit m_wr_ok(int c);
        return we && phase == 0 && !(cfg_z(c) && ws == 3'd0);
    endfunction

    function automatic logic [15:0] m_rd(int c, logic [2:0] rs);
        if (cfg_z(c) && rs == 3'd0) return 16'h0;
        if (cfg_b(c) && m_wr_ok(c) && ws == rs) return wd;
        return m_reg[c][rs];
    endfunction

    function automatic bit m_busy(int c, logic [2:0] rs);
        if (cfg_z(c) && rs == 3'd0) return 1'b0;
        if (cfg_b(c) && m_wr_ok(c) && ws == rs) return 1'b0;
        return m_pend[c][rs];
    endfunction

    task automatic m_reset();
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 8; r++) begin
                m_reg[c][r]  = 16'h0;
                m_pend[c][r] = 1'b0;
            end
        phase = 0;
    endtask

    task automatic m_tick();
        for (int c = 0; c < 3; c++) begin
            if (phase == 0) begin
                if (m_wr_ok(c)) begin
                    m_reg[c][ws]  = wd;
                    m_pend[c][ws] = 1'b0;
                end
                if (alloc_en && !(cfg_z(c) && alloc_reg == 3'd0)) m_pend[c][alloc_reg] = 1'b1;
                if (clr_req) for (int r = 0; r < 8; r++) m_pend[c][r] = 1'b0;
            end else if (phase <= 8) begin
                m_reg[c][phase-1] = 16'h0;
            end
        end
        if (phase == 0) phase = clr_req ? 1 : 0;
        else if (phase == 9) phase = 0;
        else phase = phase + 1;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("%s.c%0d.rd1", tag, c), 32'(o_rd1[c]), 32'(m_rd(c, rs1)));
            check($sformatf("%s.c%0d.rd2", tag, c), 32'(o_rd2[c]), 32'(m_rd(c, rs2)));
            check($sformatf("%s.c%0d.b1", tag, c), 32'(o_b1[c]), 32'(m_busy(c, rs1)));
            check($sformatf("%s.c%0d.b2", tag, c), 32'(o_b2[c]), 32'(m_busy(c, rs2)));
            check($sformatf("%s.c%0d.cbusy", tag, c), 32'(o_cb[c]), 32'(phase != 0));
            check($sformatf("%s.c%0d.cdone", tag, c), 32'(o_cd[c]), 32'(phase == 9));
        end
    endtask

    // Called with inputs freshly driven just after a falling edge.
    task automatic cycle(input string tag);
        #1;
        check_all(tag);
        @(posedge clk);
        m_tick();
        @(negedge clk);
    endtask

    task automatic idle_in();
        we = 1'b0; alloc_en = 1'b0; clr_req = 1'b0;
    endtask

    task automatic sweep_zero(input string tag);
        idle_in();
        for (int i = 0; i < 8; i++) begin
            rs1 = 3'(i);
            rs2 = 3'(7 - i);
            #1;
            for (int c = 0; c < 3; c++) begin
                check($sformatf("%s.c%0d.rd1_zero", tag, c), 32'(o_rd1[c]), 32'h0);
                check($sformatf("%s.c%0d.b1_zero", tag, c), 32'(o_b1[c]), 32'h0);
            end
            check_all(tag);
        end
    endtask

    task automatic fill_regs();
        for (int i = 0; i < 8; i++) begin
            we = 1'b1; ws = 3'(i); wd = 16'(i + 1);
            alloc_en = (i == 6); alloc_reg = 3'd6;
            cycle("fill");
        end
        idle_in();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, done_at, dones;
        reset = 1'b0;
        rs1 = '0; rs2 = '0; ws = '0; wd = '0; alloc_reg = '0;
        idle_in();
        m_reset();
        #12;
        sweep_zero("rst");
        @(negedge clk);
        reset = 1'b1;

        // write then read back
        we = 1'b1; ws = 3'd3; wd = 16'hA5A5; rs1 = 3'd0; rs2 = 3'd1;
        cycle("wr3");
        idle_in(); rs1 = 3'd3;
        #1;
        check("wr3.rd1", 32'(o_rd1[0]), 32'hA5A5);
        check("wr3.b1", 32'(o_b1[0]), 32'h0);
        cycle("rd3");

        // bypass on vs off
        we = 1'b1; ws = 3'd5; wd = 16'h1234; rs2 = 3'd5;
        #1;
        check("byp.on", 32'(o_rd2[0]), 32'h1234);
        check("byp.off", 32'(o_rd2[1]), 32'h0);
        cycle("byp");
        idle_in();
        #1;
        check("byp.off_next", 32'(o_rd2[1]), 32'h1234);
        cycle("byp2");

        // scoreboard
        alloc_en = 1'b1; alloc_reg = 3'd2; rs1 = 3'd2;
        cycle("alloc2");
        idle_in();
        #1;
        check("alloc2.busy", 32'(o_b1[0]), 32'h1);
        we = 1'b1; ws = 3'd2; wd = 16'h0007;
        cycle("wr2");
        idle_in();
        #1;
        check("wr2.busy", 32'(o_b1[0]), 32'h0);
        check("wr2.rd1", 32'(o_rd1[0]), 32'h0007);
        we = 1'b1; ws = 3'd4; wd = 16'hBEEF; alloc_en = 1'b1; alloc_reg = 3'd4;
        cycle("aw4");
        idle_in(); rs1 = 3'd4;
        #1;
        check("aw4.rd1", 32'(o_rd1[1]), 32'hBEEF);
        check("aw4.busy", 32'(o_b1[1]), 32'h1);
        cycle("aw4r");

        // hardwired R0
        we = 1'b1; ws = 3'd0; wd = 16'hFFFF; alloc_en = 1'b1; alloc_reg = 3'd0; rs1 = 3'd0;
        #1;
        check("r0.byp_blocked", 32'(o_rd1[2]), 32'h0);
        cycle("r0w");
        idle_in();
        #1;
        check("r0.rd1", 32'(o_rd1[1]), 32'h0);
        check("r0.busy", 32'(o_b1[1]), 32'h0);
        check("r0.plain_rd1", 32'(o_rd1[0]), 32'hFFFF);
        check("r0.plain_busy", 32'(o_b1[0]), 32'h1);
        cycle("r0r");

        // full clear with ignored traffic
        fill_regs();
        clr_req = 1'b1;
        cycle("clrreq");
        nb = 0; done_at = 0;
        for (int k = 1; k <= 9; k++) begin
            we = 1'b1; ws = 3'($urandom_range(0, 7)); wd = 16'($urandom);
            alloc_en = 1'b1; alloc_reg = 3'($urandom_range(0, 7)); clr_req = 1'b1;
            rs1 = 3'($urandom_range(0, 7)); rs2 = 3'($urandom_range(0, 7));
            #1;
            if (o_cb[0]) nb++;
            if (o_cd[0]) done_at = k;
            cycle("clr");
        end
        idle_in();
        #1;
        check("clr.busy_len", 32'(nb), 32'd9);
        check("clr.done_cycle", 32'(done_at), 32'd9);
        check("clr.busy_after", 32'(o_cb[0]), 32'h0);
        sweep_zero("clr_after");
        cycle("clr_idle");

        // reset during clear
        fill_regs();
        clr_req = 1'b1;
        cycle("clr2req");
        idle_in();
        for (int k = 0; k < 3; k++) cycle("clr2");
        #2;
        reset = 1'b0;
        #1;
        m_reset();
        check("abort.busy", 32'(o_cb[0]), 32'h0);
        sweep_zero("abort");
        @(negedge clk);
        reset = 1'b1;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (o_cd[0]) dones++;
            cycle("post_abort");
        end
        check("abort.no_done", 32'(dones), 32'd0);
        clr_req = 1'b1;
        cycle("clr3req");
        idle_in();
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (o_cd[0]) dones++;
            cycle("clr3");
        end
        check("clr3.done_once", 32'(dones), 32'd1);

        // randomised traffic
        for (int n = 0; n < 400; n++) begin
            ws  = 3'($urandom_range(0, 7));
            rs1 = ($urandom_range(0, 2) == 0) ? ws : 3'($urandom_range(0, 7));
            rs2 = ($urandom_range(0, 2) == 0) ? ws : 3'($urandom_range(0, 7));
            wd  = 16'($urandom);
            we  = $urandom_range(0, 1) == 1;
            alloc_en  = $urandom_range(0, 2) == 0;
            alloc_reg = ($urandom_range(0, 3) == 0) ? ws : 3'($urandom_range(0, 7));
            clr_req   = $urandom_range(0, 39) == 0;
            cycle("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/gprs_bank.md
Name: gprs_bank

Overview:
- Parametrised successor to the 8x16 general-purpose register file used by the processor datapath.
- Generalises width and depth, and adds optional hardwired-zero R0 and optional write-to-read bypass.
- Adds a per-register scoreboard of pending-write bits for hazard detection, and a sequential bulk-clear engine that zeroes the file one entry per cycle.
- Sits between decode (read ports, scoreboard allocate) and writeback (write port).

Parameters:
- DATA_W, 16: register width in bits.
- ADDR_W, 3: register address width; NUM_REGS = 2**ADDR_W (derived, not overridable).
- ZERO_R0, 0: when 1, R0 always reads 0, ignores writes and is never pending.
- BYPASS, 1: when 1, a same-cycle write is forwarded to matching read ports.

Ports:
- clk, in, 1: rising-edge clock.
- reset, in, 1: asynchronous, active-low reset.
- rs1, in, ADDR_W: read address 1.
- rs2, in, ADDR_W: read address 2.
- rd1, out, DATA_W: read data 1 (combinational).
- rd2, out, DATA_W: read data 2 (combinational).
- rd1_busy, out, 1: register rs1 has a pending write.
- rd2_busy, out, 1: register rs2 has a pending write.
- ws, in, ADDR_W: write address.
- wd, in, DATA_W: write data.
- we, in, 1: write enable.
- alloc_en, in, 1: mark alloc_reg as pending (a producer was issued).
- alloc_reg, in, ADDR_W: register to mark pending.
- clr_req, in, 1: request bulk clear; sampled only in IDLE.
- clr_busy, out, 1: high while the clear engine runs.
- clr_done, out, 1: one-cycle pulse when the clear completes.

Behaviour:
- Reset (reset=0, asynchronous):
  - All registers = 0 and all pending bits = 0.
  - FSM = IDLE, clear index = 0, clr_busy = 0, clr_done = 0.
  - rd1/rd2 then read 0.
- Write:
  - At a rising edge with we=1 in IDLE, reg[ws] <= wd and pending[ws] <= 0.
  - The write is ignored if ZERO_R0=1 and ws=0.
- Read:
  - rdX = reg[rsX] combinationally.
  - If ZERO_R0=1 and rsX=0, rdX = 0.
  - If BYPASS=1, we=1, FSM=IDLE and ws==rsX (and the write is not ignored), rdX = wd and rdX_busy = 0 in the same cycle.
- Scoreboard:
  - alloc_en=1 in IDLE sets pending[alloc_reg] at the edge; ignored for R0 when ZERO_R0=1.
  - rdX_busy = pending[rsX], except as overridden by bypass.
  - If alloc_en and we target the same register in the same cycle, alloc wins: the data is written and pending ends at 1.
- Clear FSM:
  - IDLE: clr_req=1 -> CLEAR; index <= 0; all pending bits <= 0.
  - CLEAR: reg[index] <= 0 each cycle and index increments. When index = NUM_REGS-1 the last entry is cleared and the FSM goes to DONE. The clear takes exactly NUM_REGS cycles.
  - DONE: clr_done = 1 for one cycle, then IDLE.
  - clr_busy = 1 in CLEAR and DONE.
  - In CLEAR/DONE, we, alloc_en and clr_req are ignored.
  - Reads stay live in CLEAR/DONE: already-cleared entries read 0, and bypass is disabled.
  - The index counter is ADDR_W bits and wraps naturally; no overflow handling is needed.
- Reset asserted mid-clear aborts immediately to the reset state, with no clr_done pulse.
- Latency:
  - Read: 0 cycles.
  - Write visible on the non-bypassed path: next cycle.
  - Clear: clr_req accepted -> clr_done exactly NUM_REGS+1 cycles later.
- Widths: no arithmetic; all addresses are in range by construction (depth = 2**ADDR_W), so there is no default/out-of-range path.

Test Plan:
- Reset, then write 16'hA5A5 to R3; next cycle rs1=3 -> rd1=16'hA5A5 and rd1_busy=0. All other registers read 0.
- BYPASS=1: in the same cycle as writing 16'h1234 to R5, rs2=5 -> rd2=16'h1234. Repeat with BYPASS=0 -> rd2=old value 0 that cycle and 16'h1234 next cycle.
- alloc_en on R2 -> rd1_busy=1 while rs1=2. Write 16'h0007 to R2 -> busy=0 next cycle. Alloc and write R4 in the same cycle -> R4 data updated and busy=1.
- ZERO_R0=1: write 16'hFFFF to R0 and alloc R0 -> rd1=0 and rd1_busy=0 at rs1=0.
- Fill R0..R7 with 1..8, pulse clr_req:
  - clr_busy is high for 9 cycles and clr_done pulses on cycle 9.
  - A we/alloc issued during the clear has no effect.
  - All registers read 0 and no pending bits are set afterward.
- Start a clear, assert reset after 3 cycles -> clr_busy=0 immediately and all registers 0. After releasing reset, no clr_done pulse ever appears and the FSM accepts a new clr_req.
